line_fill_responder: RTL
========================

// Module: line_fill_responder
// PURPOSE
// Memory-side responder that services cache line-fill requests raised by the cache MISS state.
// Accepts one line-read request per AR handshake and reads the line word-by-word from a
// synchronous SRAM port (1-cycle read latency). Returns 2**OFFSET_LENGTH beats of DATA_WIDTH
// on an R channel, critical word first, wrapping within the line; rlast marks the final beat.
// PARAMETERS
// OFFSET_LENGTH   5    log2(words per line); the line is 32 words
// DATA_WIDTH      64   word/beat width
// ADDR_WIDTH      64   request word-address width
// MEM_ADDR_WIDTH  16   SRAM word-address width; the line address is truncated to this width
// PORTS
// clk       in   1               clock; all state changes on posedge
// reset     in   1               asynchronous, active-low reset
// araddr    in   ADDR_WIDTH      requested word address; low OFFSET_LENGTH bits = critical word
// arvalid   in   1               request valid
// arready   out  1               request accepted when arvalid&arready at posedge
// rdata     out  DATA_WIDTH      returned beat
// rvalid    out  1               rdata valid
// rready    in   1               beat consumed when rvalid&rready at posedge
// rlast     out  1               high with the final beat of the line
// mem_en    out  1               SRAM read strobe
// mem_addr  out  MEM_ADDR_WIDTH  SRAM word address
// mem_rdata in   DATA_WIDTH      SRAM data, valid the cycle after mem_en
// BEHAVIOUR
// - Reset (reset=0, async): state IDLE; arready=0, rvalid=0, rlast=0, mem_en=0, mem_addr=0, rdata=0;
//   issue counter, beat counter, buffer and in-flight flag cleared. Reset mid-line drops all
//   beats; no partial line resumes. arready=1 from the first clk edge after reset deasserts.
// - FSM IDLE -> FETCH -> DRAIN -> IDLE.
//   IDLE: arready=1. On handshake latch base=araddr[.. :OFFSET_LENGTH], start=araddr[OFFSET_LENGTH-1:0].
//   FETCH: arready=0. Issue the read for beat k (k=0..2**OFFSET_LENGTH-1) at word
//     {base, (start+k) mod 2**OFFSET_LENGTH}, truncated to MEM_ADDR_WIDTH.
//     Issue only when (buf_count + inflight - pop) < 2; pop = rvalid&rready.
//     Go to DRAIN after the last issue.
//   DRAIN: arready=0; go to IDLE on the rlast handshake. A new request is never accepted
//     in the same cycle as rlast; earliest acceptance is the following cycle.
// - The offset adder wraps modulo 2**OFFSET_LENGTH and never carries into base.
//   start=31 gives the order 31,0,1,...,30.
// - mem_rdata is written into a 2-entry buffer on the cycle after mem_en.
//   rvalid/rdata come from the buffer head (registered output).
// - Latency: AR handshake in cycle T, first mem_en in T+1, first rvalid in T+3.
//   With rready held high, one beat per cycle and rlast in T+3+2**OFFSET_LENGTH-1.
// - Backpressure: while rvalid&!rready, rdata/rlast stay stable. Once the buffer plus the
//   in-flight read reaches 2, issuing stalls. No beat is dropped or duplicated.
// - rlast = (beats_returned == 2**OFFSET_LENGTH-1) && rvalid.
// - arvalid while busy is ignored (arready=0); the requester holds araddr stable until the handshake.
// STRUCTURE
// - Shared package: typedef of the FSM state enum {IDLE, FETCH, DRAIN}; localparam
//   WORDS_PER_LINE = 2**OFFSET_LENGTH; the beat-index typedef logic [OFFSET_LENGTH-1:0].
// - One sub-module, line_resp_skid: 2-entry FIFO {data, last} with push/pop/count/head outputs.
//   It allows push and pop in the same cycle at any occupancy other than full-without-pop.
// TESTING
// 1 araddr=0x1000_0040 (offset 0), rready=1 -> mem_addr 0x0040..0x005F in order;
//   32 beats; rvalid first at T+3; rlast on beat 32 only; arready=1 the cycle after.
// 2 araddr=0x...005F (offset 31) -> mem_addr order 0x5F,0x40,0x41,...,0x5E; no carry into 0x60.
// 3 rready toggles 1,0,0,1 every 4 cycles -> rdata is stable during stalls; at most 2 reads
//   are outstanding beyond the buffer; all 32 words arrive in order, each exactly once.
// 4 arvalid held high through a line -> exactly one acceptance per line; the second accept
//   happens 1 cycle after the rlast handshake.
// 5 reset driven to 0 asynchronously at beat 10 -> rvalid, arready and mem_en fall at once,
//   without a clk edge; after release a fresh request returns a full 32-beat line.
// 6 araddr bits above MEM_ADDR_WIDTH+OFFSET_LENGTH nonzero (0xFFFF_0000_0000_0123) ->
//   mem_addr uses the low 16 bits only (0x0123 first); rest of the line wraps in 0x0120..0x013F.

Source files
------------

// File: rtl/line_fill_responder_pkg.sv
// Shared definitions for the line-fill responder: line geometry, beat index
// type and the FSM state encoding.
package line_fill_responder_pkg;

  localparam int OFFSET_LENGTH  = 5;
  localparam int WORDS_PER_LINE = 2 ** OFFSET_LENGTH;

  typedef logic [OFFSET_LENGTH-1:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } lfr_state_e;

endpackage

// File: rtl/line_fill_responder_if.sv
// Request (AR) and read-data (R) channels between the cache miss logic
// (master) and the line-fill responder (slave).
//
// Handshake: a transfer happens at the rising clk edge where valid and ready
// are both high. A source that raises valid keeps valid and its payload
// (araddr, or rdata/rlast) stable until that edge; ready may change freely.
interface line_fill_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);

  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;
  logic                  rlast;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rvalid, rlast
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rvalid, rlast
  );

endinterface

// File: rtl/line_resp_skid.sv
// Two-entry FIFO holding returned SRAM words with their last-beat flag.
// slot0 is always the head, so the output is taken straight from a register.
module line_resp_skid #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] slot0_q;
  logic [W-1:0] slot1_q;
  logic [1:0]   count_q;

  // Storage and occupancy; a push while full is prevented by the issuer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_q <= push_data;
          else                 slot1_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          slot0_q <= slot1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            slot0_q <= slot1_q;
            slot1_q <= push_data;
          end else begin
            slot0_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = count_q;
  assign head  = slot0_q;

endmodule

// File: rtl/line_fill_responder.sv
// Memory-side line-fill responder: accepts one line request, reads the line
// critical-word-first from a 1-cycle SRAM and returns it as a burst of beats.
module line_fill_responder
  import line_fill_responder_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  line_fill_responder_if.slave      bus,
  output logic                      mem_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output lfr_state_e                dbg_state,
  output beat_idx_t                 dbg_beat
);

  localparam int BASE_W = MEM_ADDR_WIDTH - OFFSET_LENGTH;

  lfr_state_e          state_q, state_d;
  logic                arready_q;
  logic [BASE_W-1:0]   base_q;
  beat_idx_t           start_q;
  beat_idx_t           issue_cnt_q;
  beat_idx_t           beat_cnt_q;
  beat_idx_t           word_off;
  logic                inflight_q;
  logic                inflight_last_q;
  logic                ar_hs;
  logic                pop;
  logic                issue_ok;
  logic                last_issue;
  logic [1:0]          buf_count;
  logic [DATA_WIDTH:0] head;
  logic [2:0]          occ_next;
  logic                addr_hi_unused;

  // Request bits above the SRAM range are dropped by truncation.
  assign addr_hi_unused = ^bus.araddr[ADDR_WIDTH-1:MEM_ADDR_WIDTH];

  assign ar_hs      = bus.arvalid & arready_q;
  assign pop        = bus.rvalid & bus.rready;
  // Buffer plus in-flight read after this cycle's pop; below 2 leaves room.
  assign occ_next   = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue_ok   = (occ_next < 3'd2);
  assign last_issue = (issue_cnt_q == LAST_BEAT);
  // Offset wraps inside the line and never carries into the base.
  assign word_off   = start_q + issue_cnt_q;
  assign mem_addr   = {base_q, word_off};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and SRAM read strobe.
  always_comb begin
    state_d = state_q;
    mem_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ar_hs) state_d = FETCH;
      end
      FETCH: begin
        if (issue_ok) begin
          mem_en = 1'b1;
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && bus.rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, issue/beat counters and the in-flight read tracker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arready_q       <= 1'b0;
      base_q          <= '0;
      start_q         <= '0;
      issue_cnt_q     <= '0;
      beat_cnt_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      // Registered so it is low in reset and only rises one edge after the
      // rlast handshake.
      arready_q <= (state_d == IDLE);
      if (ar_hs) begin
        base_q      <= bus.araddr[MEM_ADDR_WIDTH-1:OFFSET_LENGTH];
        start_q     <= bus.araddr[OFFSET_LENGTH-1:0];
        issue_cnt_q <= '0;
        beat_cnt_q  <= '0;
      end else begin
        if (mem_en) issue_cnt_q <= issue_cnt_q + 1'b1;
        if (pop)    beat_cnt_q  <= beat_cnt_q + 1'b1;
      end
      inflight_q      <= mem_en;
      inflight_last_q <= mem_en & last_issue;
    end
  end

  line_resp_skid #(
    .W(DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data ({mem_rdata, inflight_last_q}),
    .pop       (pop),
    .count     (buf_count),
    .head      (head)
  );

  assign bus.arready = arready_q;
  assign bus.rvalid  = (buf_count != 2'd0);
  assign bus.rdata   = head[DATA_WIDTH:1];
  assign bus.rlast   = head[0] & bus.rvalid;

  assign dbg_state = state_q;
  assign dbg_beat  = beat_cnt_q;

endmodule
